// File: rtl/ops_sched.sv
// Window scheduler: walks an o_side x o_side output grid, issuing one engine
// window per output pixel and tracking the top-left input offset of each window.
module ops_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [2:0]  op_type,
  input  logic [3:0]  stride,
  input  logic [7:0]  i_side,
  input  logic [7:0]  o_side,
  input  logic        eng_done,
  output logic        eng_start,
  output logic [2:0]  eng_op,
  output logic [15:0] img_addr,
  output logic [15:0] out_addr,
  output logic        load_next,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ISSUE, S_WAIT, S_ADV, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [3:0]  stride_q, stride_d;
  logic [7:0]  iside_q, iside_d;
  logic [7:0]  oside_q, oside_d;
  logic [15:0] row_step_q, row_step_d;
  logic [15:0] row_base_q, row_base_d;
  logic [15:0] img_q, img_d;
  logic [15:0] out_q, out_d;
  logic [7:0]  ox_q, ox_d;
  logic [7:0]  oy_q, oy_d;
  logic        err_q, err_d;
  logic        hold_q, hold_d;

  logic        op_bad, op_nop, row_more, last_win;

  assign op_bad   = !(op_q == 3'b000 || op_q == 3'b001 || op_q == 3'b100 || op_q == 3'b101);
  assign op_nop   = (op_q == 3'b000) || (oside_q == 8'd0);
  assign row_more = ({1'b0, ox_q} + 9'd1) < {1'b0, oside_q};
  assign last_win = (ox_q == oside_q - 8'd1) && (oy_q == oside_q - 8'd1);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    stride_d   = stride_q;
    iside_d    = iside_q;
    oside_d    = oside_q;
    row_step_d = row_step_q;
    row_base_d = row_base_q;
    img_d      = img_q;
    out_d      = out_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    err_d      = err_q;
    hold_d     = hold_q;
    eng_start  = 1'b0;
    load_next  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // First IDLE cycle after load_next ignores the still-high cmd_valid.
        hold_d = 1'b0;
        if (cmd_valid && !hold_q) begin
          op_d     = op_type;
          stride_d = stride;
          iside_d  = i_side;
          oside_d  = o_side;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        row_step_d = 16'(stride_q) * 16'(iside_q);
        row_base_d = 16'd0;
        img_d      = 16'd0;
        out_d      = 16'd0;
        ox_d       = 8'd0;
        oy_d       = 8'd0;
        if (op_bad) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (op_nop) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        eng_start = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done) state_d = S_ADV;
      end
      S_ADV: begin
        if (row_more) begin
          ox_d  = ox_q + 8'd1;
          img_d = img_q + 16'(stride_q);
        end else begin
          ox_d       = 8'd0;
          oy_d       = oy_q + 8'd1;
          row_base_d = row_base_q + row_step_q;
          img_d      = row_base_q + row_step_q;
        end
        out_d   = out_q + 16'd1;
        state_d = last_win ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        load_next = 1'b1;
        hold_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= 3'd0;
      stride_q   <= 4'd0;
      iside_q    <= 8'd0;
      oside_q    <= 8'd0;
      row_step_q <= 16'd0;
      row_base_q <= 16'd0;
      img_q      <= 16'd0;
      out_q      <= 16'd0;
      ox_q       <= 8'd0;
      oy_q       <= 8'd0;
      err_q      <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      stride_q   <= stride_d;
      iside_q    <= iside_d;
      oside_q    <= oside_d;
      row_step_q <= row_step_d;
      row_base_q <= row_base_d;
      img_q      <= img_d;
      out_q      <= out_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      err_q      <= err_d;
      hold_q     <= hold_d;
    end
  end

  assign eng_op   = op_q;
  assign img_addr = img_q;
  assign out_addr = out_q;
  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;

endmodule

// File: tb/tb_ops_sched.sv
// Directed bench for ops_sched: behavioural engine responder, start/load_next
// logger, and hand-computed address sequences per command.
module tb_ops_sched;

  logic        clk = 1'b0;
  logic        rst, cmd_valid;
  logic [2:0]  op_type;
  logic [3:0]  stride;
  logic [7:0]  i_side, o_side;
  logic        eng_auto = 1'b0, eng_spur = 1'b0, eng_idle = 1'b0;
  logic        eng_done;
  logic        eng_start, load_next, busy, err;
  logic [2:0]  eng_op;
  logic [15:0] img_addr, out_addr;

  assign eng_done = eng_auto | eng_spur | eng_idle;

  ops_sched dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .op_type(op_type),
    .stride(stride), .i_side(i_side), .o_side(o_side), .eng_done(eng_done),
    .eng_start(eng_start), .eng_op(eng_op), .img_addr(img_addr),
    .out_addr(out_addr), .load_next(load_next), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // start/load_next logger
  int n_start = 0, n_ln = 0;
  logic [15:0] img_log[$], out_log[$];
  initial forever begin
    @(negedge clk);
    if (eng_start === 1'b1) begin
      n_start++;
      img_log.push_back(img_addr);
      out_log.push_back(out_addr);
    end
    if (load_next === 1'b1) n_ln++;
  end

  // engine: eng_done eng_lat cycles after each start; addresses must hold meanwhile
  int eng_lat = 3;
  int stab_bad = 0;
  initial begin
    logic [15:0] ia, oa;
    forever begin
      @(negedge clk);
      if (eng_start === 1'b1) begin
        ia = img_addr;
        oa = out_addr;
        repeat (eng_lat) @(posedge clk);
        #1 eng_auto = 1'b1;
        @(negedge clk);
        if (busy && (img_addr !== ia || out_addr !== oa)) stab_bad++;
        @(posedge clk);
        #1 eng_auto = 1'b0;
      end
    end
  end

  // spurious eng_done during ISSUE
  bit spur_en = 1'b0;
  initial forever begin
    @(negedge clk);
    if (spur_en && eng_start === 1'b1) begin
      eng_spur = 1'b1;
      @(posedge clk);
      #1 eng_spur = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic do_cmd(input logic [2:0] op, input logic [3:0] st, input logic [7:0] is,
                        input logic [7:0] os, input bit noise, output int lat_cyc);
    @(posedge clk);
    #1;
    op_type = op; stride = st; i_side = is; o_side = os; cmd_valid = 1'b1;
    lat_cyc = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (load_next === 1'b1) begin
        lat_cyc = k;
        break;
      end
      if (noise) begin
        if (k == 4) begin
          cmd_valid = 1'b0; op_type = 3'b001; stride = 4'd1; i_side = 8'd4; o_side = 8'd2;
        end
        if (k == 7)  cmd_valid = 1'b1;
        if (k == 12) cmd_valid = 1'b0;
        if (k == 13) cmd_valid = 1'b1;
      end
    end
    if (lat_cyc < 0) chk("load_next_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  int exp35[4] = '{0, 1, 4, 5};
  int exp36[9] = '{0, 2, 4, 16, 18, 20, 32, 34, 36};
  int lc, b, bl, sc;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; op_type = '0; stride = '0; i_side = '0; o_side = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_start", eng_start, 0);
    chk("rst_load_next", load_next, 0);
    chk("rst_err", err, 0);
    chk("rst_eng_op", eng_op, 0);
    chk("rst_img", img_addr, 0);
    chk("rst_out", out_addr, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // conv 2x2 over 4-wide input, 3-cycle engine
    eng_lat = 3; b = n_start; bl = n_ln;
    do_cmd(3'b001, 4'd1, 8'd4, 8'd2, 1'b0, lc);
    chk("c35_starts", n_start - b, 4);
    chk("c35_latency", lc, 22);
    for (int i = 0; i < 4; i++) begin
      chk("c35_img", img_log[b+i], exp35[i]);
      chk("c35_out", out_log[b+i], i);
    end
    chk("c35_ln", n_ln - bl, 1);
    chk("c35_eng_op", eng_op, 3'b001);
    chk("c35_err", err, 0);
    @(negedge clk);
    chk("c35_idle", busy, 0);

    // max pool 3x3, stride 2 over 8-wide input
    eng_lat = 1; b = n_start; bl = n_ln;
    do_cmd(3'b100, 4'd2, 8'd8, 8'd3, 1'b0, lc);
    chk("c36_starts", n_start - b, 9);
    chk("c36_latency", lc, 29);
    for (int i = 0; i < 9; i++) chk("c36_img", img_log[b+i], exp36[i]);
    chk("c36_out_last", out_log[b+8], 8);
    chk("c36_ln", n_ln - bl, 1);

    // idle op and empty output map
    b = n_start;
    do_cmd(3'b000, 4'd1, 8'd4, 8'd2, 1'b0, lc);
    chk("c37_op0_latency", lc, 2);
    chk("c37_op0_starts", n_start - b, 0);
    chk("c37_op0_err", err, 0);
    do_cmd(3'b001, 4'd1, 8'd4, 8'd0, 1'b0, lc);
    chk("c37_os0_latency", lc, 2);
    chk("c37_os0_starts", n_start - b, 0);
    chk("c37_os0_err", err, 0);

    // spurious eng_done in IDLE, then in ISSUE, with input churn mid-command
    b = n_start;
    @(posedge clk); #1 eng_idle = 1'b1;
    @(posedge clk); #1 eng_idle = 1'b0;
    repeat (2) @(negedge clk);
    chk("c40_idle_busy", busy, 0);
    chk("c40_idle_starts", n_start - b, 0);
    spur_en = 1'b1; eng_lat = 2; b = n_start;
    do_cmd(3'b100, 4'd2, 8'd8, 8'd3, 1'b1, lc);
    spur_en = 1'b0;
    chk("c40_starts", n_start - b, 9);
    chk("c40_latency", lc, 38);
    for (int i = 0; i < 9; i++) chk("c40_img", img_log[b+i], exp36[i]);
    chk("c40_eng_op", eng_op, 3'b100);

    // unsupported op: sticky err
    b = n_start; bl = n_ln;
    do_cmd(3'b011, 4'd1, 8'd4, 8'd2, 1'b0, lc);
    chk("c38_err", err, 1);
    chk("c38_latency", lc, 2);
    chk("c38_ln", n_ln - bl, 1);
    chk("c38_starts", n_start - b, 0);
    eng_lat = 3; b = n_start;
    do_cmd(3'b001, 4'd1, 8'd4, 8'd2, 1'b0, lc);
    chk("c38_err_sticky", err, 1);
    chk("c38_next_starts", n_start - b, 4);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("c38_err_cleared", err, 0);

    // reset during WAIT of the second window
    eng_lat = 3; b = n_start; bl = n_ln; sc = 0;
    @(posedge clk);
    #1;
    op_type = 3'b001; stride = 4'd1; i_side = 8'd4; o_side = 8'd2; cmd_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (eng_start === 1'b1) sc++;
      if (sc == 2) break;
    end
    chk("c39_reached_w2", sc, 2);
    @(posedge clk); #1 rst = 1'b1; cmd_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("c39_busy", busy, 0);
    repeat (8) @(negedge clk);
    chk("c39_no_ln", n_ln - bl, 0);
    chk("c39_no_extra", n_start - b, 2);
    chk("c39_busy_after", busy, 0);
    b = n_start;
    do_cmd(3'b001, 4'd1, 8'd4, 8'd2, 1'b0, lc);
    chk("c39_restart_starts", n_start - b, 4);
    chk("c39_restart_img0", img_log[b], 0);
    chk("c39_restart_latency", lc, 22);

    chk("addr_stable", stab_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ops_sched.md
OPS_SCHED -- requirements
Module: ops_sched

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all logic is on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-003 SHALL have port cmd_valid, input, 1, level signal; high while the command block holds a decoded command in its run state.
REQ-004 SHALL have port op_type, input, 3, operation code: 000 idle, 001 conv+ReLU, 100 max pool, 101 avg pool.
REQ-005 SHALL have port stride, input, 4, window step in pixels.
REQ-006 SHALL have port i_side, input, 8, input feature-map side length.
REQ-007 SHALL have port o_side, input, 8, output feature-map side length.
REQ-008 SHALL have port eng_done, input, 1, one-cycle pulse from the compute engine when the current window is finished.
REQ-009 SHALL have port eng_start, output, 1, one-cycle pulse that starts one window on the engine.
REQ-010 SHALL have port eng_op, output, 3, latched op_type passed to the engine.
REQ-011 SHALL have port img_addr, output, 16, pixel offset of the window's top-left corner.
REQ-012 SHALL have port out_addr, output, 16, linear output pixel index.
REQ-013 SHALL have port load_next, output, 1, one-cycle pulse: command complete.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port err, output, 1, sticky flag set on an unsupported op_type.

Function
REQ-016 SHALL implement states IDLE, SETUP, ISSUE, WAIT, ADVANCE, DONE.
REQ-017 IDLE->SETUP when cmd_valid=1.
- Latch op_type, stride, i_side and o_side on that edge.
- Input changes made later SHALL be ignored until the next IDLE.
REQ-018 SETUP SHALL last one cycle.
- Register row_step = stride*i_side (16-bit).
- Clear ox, oy, row_base, img_addr, out_addr to 0.
REQ-019 SETUP->DONE directly, with no eng_start, when any of these holds:
- op_type=000;
- o_side=0;
- op_type is not 001, 100 or 101; err is also set to 1 in this case.
REQ-020 Otherwise SETUP->ISSUE.
REQ-021 ISSUE SHALL assert eng_start for exactly one cycle, then go to WAIT.
REQ-022 img_addr and out_addr SHALL be stable from the ISSUE cycle until eng_done is seen.
REQ-023 WAIT->ADVANCE on eng_done=1. eng_done outside WAIT SHALL be ignored.
REQ-024 ADVANCE pixel step:
- If ox+1 < o_side: ox += 1, img_addr += stride.
- Else: ox = 0, oy += 1, row_base += row_step, img_addr = row_base + row_step.
- out_addr += 1 in both cases.
REQ-025 ADVANCE->DONE when the finished window was ox=o_side-1 and oy=o_side-1; else ADVANCE->ISSUE.
REQ-026 DONE SHALL pulse load_next for one cycle, then return to IDLE.
REQ-027 In IDLE, cmd_valid is not re-sampled until one cycle after load_next.
- The command block drops cmd_valid in response to load_next.
REQ-028 Address arithmetic SHALL wrap modulo 2^16 with no saturation and no error.
REQ-029 Per-window cost SHALL be: 1 cycle ISSUE + engine latency + 1 cycle ADVANCE.
REQ-030 Window count per command SHALL be exactly o_side*o_side.
REQ-031 eng_op SHALL hold the latched op_type from SETUP until the next SETUP.

Reset
REQ-032 While rst=1, outputs SHALL be:
- state = IDLE;
- eng_start = 0, load_next = 0, busy = 0, err = 0;
- eng_op = 0, img_addr = 0, out_addr = 0;
- internal counters = 0.
REQ-033 rst asserted mid-command (any state) SHALL abort the command at the next edge.
- No load_next pulse is issued for the aborted command.
REQ-034 err SHALL clear only on rst.

Verification
REQ-035 op=001, stride=1, i_side=4, o_side=2, eng_done 3 cycles after each start:
- expect 4 eng_start pulses;
- img_addr sequence 0, 1, 4, 5 and out_addr sequence 0, 1, 2, 3;
- one load_next.
REQ-036 op=100, stride=2, i_side=8, o_side=3:
- expect img_addr sequence 0, 2, 4, 16, 18, 20, 32, 34, 36;
- 9 starts, then load_next.
REQ-037 op=000, or o_side=0:
- expect load_next 2 cycles after cmd_valid;
- no eng_start, err=0.
REQ-038 op=011:
- expect err=1 and load_next;
- no eng_start; err stays 1 over the following commands until rst.
REQ-039 rst pulsed during WAIT of window 2:
- expect busy=0 and no load_next;
- a following command restarts at img_addr=0.
REQ-040 Spurious eng_done in ISSUE or IDLE, and cmd_valid toggling mid-command:
- expect no extra windows and unchanged latched parameters.
